// File: rtl/worker_mem_slave_if.sv
// Avalon-MM single-beat command/response bundle between the worker master and the memory slave.
interface worker_mem_slave_if;
  logic [27:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        burstcount;
  logic        debugaccess;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable, burstcount, debugaccess,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount, debugaccess,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/worker_mem_slave.sv
// Avalon-MM memory slave: accepted commands queue in a small FIFO and execute in order
// against an on-chip word memory; reads answer through a two-edge readdatavalid pipeline.
module worker_mem_slave #(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] OOR_DATA   = 32'hDEADBEEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  worker_mem_slave_if.slave   worker_in,
  output logic [15:0]         err_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef struct packed {
    logic          is_write;
    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } cmd_t;

  cmd_t        fifo_r [FIFO_DEPTH];
  logic [PW:0] wr_ptr_r;
  logic [PW:0] rd_ptr_r;
  logic [31:0] mem_r [MEM_WORDS];
  logic [31:0] mem_q_r;
  logic        rd_pend_r;
  logic        rd_oor_r;
  logic [31:0] readdata_r;
  logic        rdv_r;
  logic [15:0] err_r;

  logic        full_s;
  logic        empty_s;
  logic        waitreq_s;
  logic        push_s;
  logic        pop_s;
  logic        collide_s;
  cmd_t        push_cmd_s;
  cmd_t        pop_cmd_s;
  logic [1:0]  err_inc_s;
  logic [16:0] err_sum_s;
  logic        unused_s;

  // FIFO status, handshake decode and error-increment arithmetic
  always_comb begin
    full_s    = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
    empty_s   = (wr_ptr_r == rd_ptr_r);
    waitreq_s = reset_reset | full_s;
    push_s    = (worker_in.read | worker_in.write) & ~waitreq_s;
    collide_s = push_s & worker_in.read & worker_in.write;
    pop_s     = ~empty_s & ~reset_reset;

    // A read+write collision is queued as a write, so is_write follows write alone.
    push_cmd_s.is_write = worker_in.write;
    push_cmd_s.idx      = worker_in.address[AW+1:2];
    push_cmd_s.in_range = (worker_in.address[27:AW+2] == {(26-AW){1'b0}});
    push_cmd_s.wdata    = worker_in.writedata;
    push_cmd_s.be       = worker_in.byteenable;

    pop_cmd_s = fifo_r[rd_ptr_r[PW-1:0]];

    err_inc_s = {1'b0, collide_s} + {1'b0, pop_s & ~pop_cmd_s.in_range};
    err_sum_s = {1'b0, err_r} + {15'd0, err_inc_s};
  end

  // Control state: pointers, read-response pipeline and saturating error counter
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_r   <= {(PW+1){1'b0}};
      rd_ptr_r   <= {(PW+1){1'b0}};
      rd_pend_r  <= 1'b0;
      rd_oor_r   <= 1'b0;
      rdv_r      <= 1'b0;
      readdata_r <= 32'd0;
      err_r      <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      rd_pend_r <= pop_s & ~pop_cmd_s.is_write;
      rd_oor_r  <= ~pop_cmd_s.in_range;
      rdv_r     <= rd_pend_r;
      if (rd_pend_r) begin
        readdata_r <= rd_oor_r ? OOR_DATA : mem_q_r;
      end
      err_r <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
    end
  end

  // Command storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk_clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r[PW-1:0]] <= push_cmd_s;
    end
  end

  // Word memory: byte-lane writes and synchronous read at the pop edge, never reset
  always_ff @(posedge clk_clk) begin
    if (pop_s && pop_cmd_s.is_write && pop_cmd_s.in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (pop_cmd_s.be[i]) begin
          mem_r[pop_cmd_s.idx][8*i +: 8] <= pop_cmd_s.wdata[8*i +: 8];
        end
      end
    end
    if (pop_s) begin
      mem_q_r <= mem_r[pop_cmd_s.idx];
    end
  end

  assign worker_in.waitrequest   = waitreq_s;
  assign worker_in.readdata      = readdata_r;
  assign worker_in.readdatavalid = rdv_r;
  assign err_count               = err_r;

  assign unused_s = &{1'b0, worker_in.burstcount, worker_in.debugaccess, worker_in.address[1:0]};

endmodule
